bubble_position_tracker: RTL

BUBBLE_POSITION_TRACKER -- requirements
Module: bubble_position_tracker

---
 rtl/bubble_position_tracker.sv | 107 ++++++++++
 1 files changed

// File: rtl/bubble_position_tracker.sv
// Bubble-memory minor-loop position counter with latch handshake.
// Optional latch_overrun output enabled by macro BUBBLE_LATCH_OVERRUN_EN.
module bubble_position_tracker #(
   parameter int LOOP_LENGTH = 2053
) (
   input  logic        master_clock,
   input  logic        master_reset,
   input  logic        position_change,
   input  logic        position_latch,
   input  logic        coil_enable,
   input  logic        position_load,
   input  logic [11:0] load_value,
   input  logic        latch_ack,
   output logic [11:0] current_position,
   output logic [11:0] latched_position,
   output logic        latch_valid,
   output logic        position_rollover
`ifdef BUBBLE_LATCH_OVERRUN_EN
   ,
   output logic        latch_overrun
`endif
);

   localparam logic [11:0] LEN  = 12'(LOOP_LENGTH);
   localparam logic [11:0] LAST = 12'(LOOP_LENGTH - 1);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t      state;
   logic        chg_r, chg_d;
   logic        lat_r, lat_d;
   logic        coil_r;
   logic        seeded;
   logic        step;
   logic        lat_edge;
   logic        wrap;
   logic [11:0] next_pos;

   assign step        = chg_r & ~chg_d & ~coil_r;
   assign lat_edge    = lat_r & ~lat_d;
   assign latch_valid = (state == FULL);

   always_comb begin
      next_pos = current_position;
      wrap     = 1'b0;
      if (position_load) begin
         next_pos = (load_value < LEN) ? load_value : 12'd0;
      end else if (step) begin
         if (current_position == LAST) begin
            next_pos = 12'd0;
            wrap     = 1'b1;
         end else begin
            next_pos = current_position + 12'd1;
         end
      end
   end

   always_ff @(posedge master_clock) begin
      if (master_reset) begin
         chg_r             <= 1'b0;
         chg_d             <= 1'b0;
         lat_r             <= 1'b0;
         lat_d             <= 1'b0;
         coil_r            <= 1'b0;
         seeded            <= 1'b0;
         current_position  <= 12'd0;
         latched_position  <= 12'd0;
         position_rollover <= 1'b0;
         state             <= EMPTY;
`ifdef BUBBLE_LATCH_OVERRUN_EN
         latch_overrun     <= 1'b0;
`endif
      end else begin
         chg_r  <= position_change;
         lat_r  <= position_latch;
         coil_r <= coil_enable;
         seeded <= 1'b1;
         // First sample after reset seeds the history so a level
         // still high at release is not mistaken for an edge.
         chg_d  <= seeded ? chg_r : position_change;
         lat_d  <= seeded ? lat_r : position_latch;
         current_position  <= next_pos;
         position_rollover <= wrap;
         unique case (state)
            EMPTY: begin
               if (lat_edge) begin
                  latched_position <= next_pos;
                  state            <= FULL;
               end
            end
            FULL: begin
               if (latch_ack) begin
                  if (lat_edge) latched_position <= next_pos;
                  else          state            <= EMPTY;
               end
`ifdef BUBBLE_LATCH_OVERRUN_EN
               else if (lat_edge) begin
                  latch_overrun <= 1'b1;
               end
`endif
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule
